// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path: the sequencer state
// encoding, instruction-class field positions and the machine word width.
package cpu_pkg;

  localparam int WORD_W      = 16;
  localparam int IR_CLASS_HI = 15;
  localparam int IR_CLASS_LO = 14;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_IDLE   = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  // True for the states that make up an instruction in flight (FETCH..WB).
  function automatic logic is_active(state_t s);
    return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) ||
           (s == ST_MEM) || (s == ST_WB);
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Wait counter for the RAM req/ack handshake. Counts cycles spent waiting
// in FETCH or MEM without an ack and flags the cycle in which the limit is
// reached. An ack in that same cycle suppresses the timeout.
// ACK_TIMEOUT = 0 disables the timeout entirely.
module ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ack,
  output logic timeout
);

  localparam int TMR_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  logic [TMR_W-1:0] wait_q;
  logic [TMR_W-1:0] wait_d;

  // Count up while a request is outstanding; anything else (ack or leaving
  // the waiting states) returns the counter to zero for the next entry.
  always_comb begin
    wait_d = '0;
    if (waiting && !mem_ack) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  generate
    if (ACK_TIMEOUT > 0) begin : g_limit
      localparam logic [TMR_W-1:0] LAST_WAIT = TMR_W'(ACK_TIMEOUT - 1);
      assign timeout = waiting && !mem_ack && (wait_q == LAST_WAIT);
    end else begin : g_no_limit
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-phase control sequencer for the 16-bit CPU:
// FETCH -> DECODE -> EXEC -> [MEM] -> WB, with HALT and FAULT absorbing
// states and performance counters for the debug display.
// Optional single-step support is compiled in with SINGLE_STEP_EN, which
// adds the step_mode and step ports.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             mem_access,
  input  logic             is_store,
  input  logic             halt_req,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_count,
  output logic             reg_load,
  output logic             exec,
  output logic [2:0]       phase,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
`ifdef SINGLE_STEP_EN
  ,
  input  logic             step_mode,
  input  logic             step
`endif
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cycle_count_q;
  logic [CNT_W-1:0] cycle_count_d;
  logic [CNT_W-1:0] instr_count_q;
  logic [CNT_W-1:0] instr_count_d;
  logic             waiting;
  logic             timeout;
  logic             start_go;
  logic             wb_continue;

`ifdef SINGLE_STEP_EN
  logic step_q;
  logic step_d;
  logic step_rise;

  // Remember last cycle's step level so a held button starts only one instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_d      = step;
  assign step_rise   = step && !step_q;
  assign start_go    = step_mode ? step_rise : run;
  assign wb_continue = run && !step_mode;
`else
  assign start_go    = run;
  assign wb_continue = run;
`endif

  assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

  ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .waiting(waiting),
    .mem_ack(mem_ack),
    .timeout(timeout)
  );

  // Next-state logic; run is only consulted in IDLE and WB so a dropped run
  // lets the current instruction finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_go) state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack)      state_d = ST_DECODE;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_DECODE: state_d = halt_req ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_d = mem_access ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (mem_ack)      state_d = ST_WB;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_WB:     state_d = wb_continue ? ST_FETCH : ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Performance counters: active cycles and retired instructions, both wrapping.
  always_comb begin
    cycle_count_d = cycle_count_q;
    instr_count_d = instr_count_q;
    if (is_active(state_q)) begin
      cycle_count_d = cycle_count_q + 1'b1;
    end
    if (state_q == ST_WB) begin
      instr_count_d = instr_count_q + 1'b1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Output decode from the registered state; fetch strobes also need the ack.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_load  = 1'b0;
    pc_count = 1'b0;
    reg_load = 1'b0;
    exec     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ir_load  = mem_ack;
        pc_count = mem_ack;
      end
      ST_EXEC: exec = 1'b1;
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        exec    = 1'b1;
      end
      ST_WB: begin
        exec     = 1'b1;
        reg_load = !(mem_access && is_store);
      end
      default: ;
    endcase
  end

  assign phase       = state_q;
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_FAULT);
  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-phase control sequencer for the 16-bit CPU. Replaces the two-phase fetch/exec toggle.
Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB. RAM accesses use a req/ack handshake with a timeout.
Drives the ir/pc/register load strobes and exports performance counters to the seven-segment debug mux.

Parameters:
ACK_TIMEOUT, 15, max cycles waiting for mem_ack before FAULT; 0 disables the timeout
CNT_W, 16, width of cycle_count and instr_count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  level; high = sequencer may start or continue instructions
mem_access  in  1  decoder: current IR is a load/store (valid from DECODE onward)
is_store  in  1  decoder: current IR is a store
halt_req  in  1  decoder: current IR is HALT
mem_ack  in  1  RAM completes the current request this cycle
mem_req  out  1  RAM request, held until ack
mem_we  out  1  write qualifier for mem_req
ir_load  out  1  one-cycle strobe: load IR from RAM data
pc_count  out  1  one-cycle strobe: increment r7
reg_load  out  1  one-cycle strobe: write destination register
exec  out  1  high in EXEC, MEM and WB (compatible with the old exec LED and muxes)
phase  out  3  current state encoding
halted  out  1  state == HALT
fault  out  1  state == FAULT
cycle_count  out  CNT_W  active cycles
instr_count  out  CNT_W  retired instructions

Behaviour:
- States and encodings: IDLE=5, FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=6, FAULT=7. All state is Moore and registered; outputs decode combinationally from the state and counters.
- Reset (asynchronous, any time, including mid-handshake):
  - state=IDLE; counters=0; wait counter=0.
  - All strobes, mem_req, mem_we, halted and fault read 0 immediately.
- IDLE:
  - run=1 goes to FETCH next cycle.
  - run=0 stays in IDLE.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ack: ir_load=1 and pc_count=1 in that same cycle, then go to DECODE.
  - Ack arriving in the first FETCH cycle is legal, giving a minimum fetch of 1 cycle.
- DECODE: one cycle.
  - halt_req=1 goes to HALT.
  - Otherwise go to EXEC.
- EXEC: one cycle.
  - mem_access=1 goes to MEM.
  - Otherwise go to WB.
- MEM:
  - mem_req=1, mem_we=is_store.
  - On mem_ack go to WB.
- WB: one cycle.
  - reg_load=1 unless (mem_access & is_store).
  - instr_count increments.
  - run=1 goes to FETCH; run=0 goes to IDLE.
- Latency: a minimum non-memory instruction is 4 cycles (FETCH..WB); a memory instruction is 5 plus the ack waits.
- run only matters in IDLE and WB. Dropping run mid-instruction completes that instruction.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle in those states without ack.
  - If ACK_TIMEOUT>0 and the counter reaches ACK_TIMEOUT with no ack, go to FAULT; mem_req drops that cycle.
  - Ack in the same cycle the limit is reached wins (no fault).
- HALT and FAULT are absorbing until reset. Late acks there are ignored.
- cycle_count increments every cycle in FETCH..WB, not in IDLE, HALT or FAULT.
- Both counters wrap modulo 2^CNT_W without saturation.
- mem_ack outside FETCH/MEM is ignored.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- With the macro, the block adds two ports: step_mode (in, 1) and step (in, 1, raw synchronous button after debounce).
  - When step_mode=1, WB always goes to IDLE.
  - IDLE goes to FETCH on a rising edge of step (registered edge detect, reset to 0), regardless of run.
  - One edge executes exactly one instruction.
  - When step_mode=0, behaviour is identical to the build without the macro.
- Without the macro, the ports are absent and IDLE/WB obey run only.

Decomposition:
- Shared package cpu_pkg:
  - state encoding constants (IDLE..FAULT)
  - instruction class field positions (ir[15:14])
  - the 16-bit word width constant
- One natural sub-module: ack_timer, the wait counter plus timeout compare, parametrised by ACK_TIMEOUT.
- The edge detect stays inline.

Test Plan:
1. Reset, run=1, mem_ack tied 1, non-memory instr -> phases 0,1,2,4 repeat; instr_count=3 after 12 cycles; cycle_count=12; ir_load/pc_count each pulse once per instr.
2. Load instr, mem_access=1, is_store=0, MEM ack after 3 cycles -> mem_req high 3 cycles with mem_we=0; reg_load at WB; instruction takes 7 cycles.
3. Store instr -> mem_we=1 during MEM, no reg_load in WB.
4. ACK_TIMEOUT=4, never ack in FETCH -> FAULT after 4 FETCH cycles, fault=1, mem_req=0, cycle_count frozen; ack at cycle 4 instead -> DECODE, no fault.
5. halt_req at DECODE -> halted=1 permanently; assert reset mid-MEM of a later run -> phase=5, all strobes 0 asynchronously.
6. SINGLE_STEP_EN, step_mode=1: three step edges -> instr_count=3, IDLE between each; holding step high yields one instruction only.
